// File: rtl/bit_unpacker.sv
// Bit unpacker: buffers 64-bit words LSB-first in a 128-bit residue and
// emits variable-width (1..64) fields through a single registered output slot.
module bit_unpacker (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  input  logic        req_valid,
  input  logic [5:0]  req_width,
  output logic        req_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic        out_ready,
  input  logic        flush,
  output logic [7:0]  level
);

  logic [127:0] buf_q, buf_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         out_valid_q, out_valid_d;
  logic [63:0]  out_data_q, out_data_d;

  logic [6:0]   w_s;
  logic [6:0]   w_taken_s;
  logic [7:0]   cnt_eff_s;
  logic [63:0]  field_mask_s;
  logic [127:0] shifted_s;
  logic [127:0] word_pos_s;
  logic         slot_free_s;
  logic         in_fire_s;
  logic         req_fire_s;

  // Handshake readiness from registered state; a zero width encodes 64.
  always_comb begin
    w_s         = (req_width == 6'd0) ? 7'd64 : {1'b0, req_width};
    slot_free_s = !out_valid_q || out_ready;
    in_ready    = (cnt_q <= 8'd64) && !flush;
    req_ready   = (cnt_q >= {1'b0, w_s}) && !flush && slot_free_s;
    in_fire_s   = in_valid && in_ready;
    req_fire_s  = req_valid && req_ready;
  end

  // Field extraction and the residue update; the consumed width is removed
  // before the new word lands so a same-cycle push and pull stay contiguous.
  always_comb begin
    w_taken_s    = req_fire_s ? w_s : 7'd0;
    cnt_eff_s    = cnt_q - {1'b0, w_taken_s};
    field_mask_s = (w_s == 7'd64) ? {64{1'b1}} : ((64'd1 << w_s[5:0]) - 64'd1);
    shifted_s    = buf_q >> w_taken_s;
    word_pos_s   = {64'd0, in_data} << cnt_eff_s;

    buf_d = buf_q;
    cnt_d = cnt_q;
    if (flush) begin
      buf_d = 128'd0;
      cnt_d = 8'd0;
    end else if (in_fire_s) begin
      buf_d = shifted_s | word_pos_s;
      cnt_d = cnt_eff_s + 8'd64;
    end else begin
      buf_d = shifted_s;
      cnt_d = cnt_eff_s;
    end
  end

  // Output slot: load on request, drain on out_ready, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (req_fire_s) begin
      out_valid_d = 1'b1;
      out_data_d  = buf_q[63:0] & field_mask_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= 128'd0;
      cnt_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = cnt_q;

endmodule

// File: doc/bit_unpacker.md
BIT_UNPACKER -- requirements
Module: bit_unpacker

Interface
REQ-001 The block SHALL have port clock, input, 1, the single rising-edge clock for all state.
REQ-002 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-003 The block SHALL have port in_valid, input, 1, upstream word valid.
REQ-004 The block SHALL have port in_data, input, 64, upstream word; bits are consumed LSB-first.
REQ-005 The block SHALL have port in_ready, output, 1, word accepted on a cycle where in_valid && in_ready.
REQ-006 The block SHALL have port req_valid, input, 1, field-extract request valid.
REQ-007 The block SHALL have port req_width, input, 6, field width; 1..63 literal, 0 means 64.
REQ-008 The block SHALL have port req_ready, output, 1, request accepted on a cycle where req_valid && req_ready.
REQ-009 The block SHALL have port out_valid, output, 1, extracted field valid.
REQ-010 The block SHALL have port out_data, output, 64, extracted field, zero-extended above the width.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts the field.
REQ-012 The block SHALL have port flush, input, 1, synchronous discard of all buffered bits.
REQ-013 The block SHALL have port level, output, 8, number of buffered unconsumed bits, range 0..128.

Function
REQ-014 The block SHALL hold a 128-bit residue buffer buf and a bit count cnt; valid bits are buf[cnt-1:0].
REQ-015 in_ready SHALL be 1 when cnt <= 64 and flush is 0; it is combinational from registered state only.
REQ-016 On word accept, in_data SHALL be written at bit position cnt_eff, where cnt_eff = cnt - w_taken, w_taken is the width consumed this cycle (0 if none), and cnt' = cnt_eff + 64.
REQ-017 The effective width w SHALL be req_width, or 64 when req_width == 0.
REQ-018 req_ready SHALL be 1 when cnt >= w, flush is 0, and either out_valid == 0 or out_ready == 1.
REQ-019 On request accept, the next out_data SHALL be buf[w-1:0] zero-extended, the buffer SHALL shift right by w, out_valid SHALL be 1 next cycle, and cnt SHALL decrease by w.
REQ-020 Field latency SHALL be 1 cycle from request accept to out_valid.
REQ-021 The output SHALL be a single registered slot.
REQ-022 While out_valid && !out_ready, out_data and out_valid SHALL hold stable.
REQ-023 When the output slot drains with no new request accepted, out_valid SHALL go to 0 next cycle.
REQ-024 Simultaneous word accept and request accept SHALL both take effect in one cycle per REQ-016/REQ-019, with no bit lost or duplicated.
REQ-025 A request with cnt < w SHALL stall with req_ready = 0; partial fields SHALL never be emitted.
REQ-026 cnt SHALL never exceed 128.
REQ-027 A field straddling a word boundary SHALL concatenate the older bits as the LSBs.
REQ-028 While flush is 1, the block SHALL accept no word and no request.
REQ-029 On the clock edge where flush is 1, cnt and buf SHALL be cleared.
REQ-030 On the clock edge where flush is 1, an already-valid output SHALL be unaffected and SHALL complete its handshake normally.
REQ-031 level SHALL equal cnt, registered.

Reset
REQ-032 While rst_n == 0, the block SHALL asynchronously force buf = 0, cnt = 0, out_valid = 0, out_data = 0, level = 0.
REQ-033 Consequently, in_ready SHALL be 1 and req_ready SHALL be 0 during and immediately after reset.
REQ-034 Reset asserted mid-transfer SHALL discard all buffered bits and any pending output; no field SHALL be emitted after reset until a new word arrives.

Verification
REQ-035 The bench SHALL push word 64'h1234567812345678, then request width 4, then width 8 -> out_data 64'h8, then 64'h67; level goes 64 -> 60 -> 52.
REQ-036 The bench SHALL push 64'h1234567812345678 and request width 60 (-> 64'h234567812345678), then push 64'h00000000DEADBEEF and request width 8 -> out_data 64'hF1, level 60.
REQ-037 The bench SHALL push two words, check that in_ready drops at level 128, request width 0 (64) -> returns the first word, and check that in_ready reasserts.
REQ-038 The bench SHALL hold out_ready = 0 with a field pending -> out_data stable and req_ready = 0 for 5 cycles; then raise out_ready with req_valid held -> back-to-back fields on consecutive cycles.
REQ-039 The bench SHALL present a word and a width-16 request on the same cycle with level 16 -> field equals the old 16 bits and level ends at 64.
REQ-040 The bench SHALL pulse flush at level 40 -> level 0 next cycle and a request of width 1 stalls; separately, drop rst_n mid-stream -> all outputs 0 asynchronously.
